// File: rtl/rs232_rx.sv
`default_nettype none
// ============================================================================
// Module   : rs232_rx
// Brief    : 8N1 RS232 receiver, LSB first, bit-centre sampling, with
//            CPU handshake (rdy/done), framing-error and sticky overrun flags.
// Revision : 1.0 - initial release
// ============================================================================
module rs232_rx #(
  parameter int DIV_SLOW = 1302,
  parameter int DIV_FAST = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fsel,
  input  logic       RxD,
  input  logic       done,
  output logic [7:0] data,
  output logic       rdy,
  output logic       ferr,
  output logic       ovr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        meta_q, rxs_q;
  logic [11:0] tick_q, tick_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic        complete;

  logic [11:0] limit;
  logic [11:0] half;

  assign limit = fsel ? 12'(DIV_FAST) : 12'(DIV_SLOW);
  assign half  = limit >> 1;

  // Receive FSM next state plus the CPU-facing output registers.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q + 12'd1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    case (state_q)
      S_IDLE: begin
        tick_d = 12'd0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        // Re-check the line half a bit in; a short low pulse is discarded.
        if (tick_q == half) begin
          tick_d = 12'd0;
          if (!rxs_q) begin
            state_d  = S_DATA;
            bitcnt_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick_q == limit) begin
          tick_d   = 12'd0;
          shreg_d  = {rxs_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_q == limit) begin
          tick_d   = 12'd0;
          complete = 1'b1;
          state_d  = rxs_q ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // A line held low must return high before another start bit counts.
        tick_d = 12'd0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = 12'd0;
      end
    endcase

    // A completing byte takes priority over the CPU acknowledge.
    if (complete) begin
      data_d = shreg_q;
      rdy_d  = 1'b1;
      ferr_d = ~rxs_q;
      if (rdy_q && !done) ovr_d = 1'b1;
    end else if (done) begin
      rdy_d = 1'b0;
    end
  end

  // State, synchroniser and output registers; everything freezes when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      meta_q   <= 1'b1;
      rxs_q    <= 1'b1;
      tick_q   <= 12'd0;
      bitcnt_q <= 3'd0;
      shreg_q  <= 8'd0;
      data_q   <= 8'd0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else if (enable) begin
      state_q  <= state_d;
      meta_q   <= RxD;
      rxs_q    <= meta_q;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign data = data_q;
  assign rdy  = rdy_q;
  assign ferr = ferr_q;
  assign ovr  = ovr_q;

endmodule
`default_nettype wire
